// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - RV32I integer register file with bypass, busy scoreboard and clear sequencer
// Two async read ports, one sync write port; x0 reads as zero and is never stored.
module regfile_sb #(
    parameter  int XLEN   = 32,
    parameter  int NREG   = 32,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear_req,
    output logic            ready,
    input  logic            WE,
    input  logic [AW-1:0]   AddD,
    input  logic [XLEN-1:0] DataD,
    input  logic [AW-1:0]   AddA,
    output logic [XLEN-1:0] DataA,
    input  logic [AW-1:0]   AddB,
    output logic [XLEN-1:0] DataB,
    input  logic            issue_vld,
    input  logic [AW-1:0]   issue_rd,
    output logic            busyA,
    output logic            busyB
);

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);
    localparam logic [AW-1:0] FIRST_IDX = AW'(1);

    state_t          state;
    logic [AW-1:0]   idx;
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busyNext;
    logic [XLEN-1:0] xreg [NREG];

    logic writeEn;
    logic bypassA;
    logic bypassB;

    assign writeEn = ready && WE && (AddD != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
            idx   <= FIRST_IDX;
            busy  <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (idx == LAST_IDX) begin
                        state <= IDLE;
                        ready <= 1'b1;
                    end else begin
                        idx <= idx + AW'(1);
                    end
                end
                IDLE: begin
                    if (clear_req) begin
                        state <= CLEAR;
                        idx   <= FIRST_IDX;
                        busy  <= '0;
                        ready <= 1'b0;
                    end else begin
                        busy <= busyNext;
                    end
                end
                default: begin
                    state <= CLEAR;
                    idx   <= FIRST_IDX;
                    busy  <= '0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // Storage carries no reset: the clear sequencer zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            xreg[idx] <= '0;
        end else if (writeEn) begin
            xreg[AddD] <= DataD;
        end
    end

    // A new issue to r outranks a writeback to r: the issued instruction is the newer producer.
    always_comb begin
        busyNext = busy;
        for (int r = 1; r < NREG; r++) begin
            if (issue_vld && (issue_rd == AW'(r))) begin
                busyNext[r] = 1'b1;
            end else if (WE && (AddD == AW'(r))) begin
                busyNext[r] = 1'b0;
            end
        end
        busyNext[0] = 1'b0;
    end

    assign bypassA = (BYPASS != 0) && WE && (AddD == AddA) && (AddA != '0);
    assign bypassB = (BYPASS != 0) && WE && (AddD == AddB) && (AddB != '0);

    always_comb begin
        DataA = '0;
        DataB = '0;
        busyA = 1'b0;
        busyB = 1'b0;
        if (ready) begin
            if (AddA != '0) begin
                DataA = bypassA ? DataD : xreg[AddA];
            end
            if (AddB != '0) begin
                DataB = bypassB ? DataD : xreg[AddB];
            end
            busyA = busy[AddA] && !bypassA;
            busyB = busy[AddB] && !bypassB;
        end
    end

endmodule
